jump_ctrl: RTL and testbench

Execute-stage jump/branch controller for the RockWave core. It accepts one instruction per handshake from the execute stage and samples the branch comparator result (`jump_state_pre` from `comp`). For taken branches and JAL/JALR it computes the target and runs a redirect handshake with fetch. It then holds a pipeline flush for a fixed number of cycles and keeps saturating branch statistics.

---
 rtl/jump_ctrl.sv | 156 +++++++++++++++
 tb/tb_jump_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jump_ctrl
// Purpose  : Execute-stage branch/jump resolver. Drives the fetch redirect
//            handshake and the post-redirect flush, and keeps branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module jump_ctrl #(
    parameter int XLEN         = 32,
    parameter int OPLEN        = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exec_valid,
    output logic              exec_ready,
    input  logic [1:0]        br_type,
    input  logic [OPLEN-1:0]  decoded_op_de,
    input  logic              jump_state_pre,
    input  logic [XLEN-1:0]   pc_de,
    input  logic [XLEN-1:0]   imm_de,
    input  logic [XLEN-1:0]   rs1data_de,
    output logic              redirect_req,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              redirect_ack,
    output logic              flush,
    output logic              illegal_br,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0]       C_FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

    state_t            state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   rpc_q, rpc_d;
    logic              flush_q, flush_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;

    logic [2:0]        w_funct3;
    logic              w_accept;
    logic              w_f3_illegal;
    logic              w_cond_ok;
    logic              w_take;
    logic [XLEN-1:0]   w_target;
    logic              w_unused_op;

    assign w_funct3     = decoded_op_de[6:4];
    assign w_unused_op  = ^{decoded_op_de[OPLEN-1:7], decoded_op_de[3:0]};
    assign w_accept     = exec_valid & exec_ready;
    // funct3 010/011 are not branch encodings; the comparator output is ignored for them
    assign w_f3_illegal = (w_funct3[2:1] == 2'b01);
    assign w_cond_ok    = (br_type == 2'b01) & ~w_f3_illegal;
    assign w_take       = br_type[1] | (w_cond_ok & jump_state_pre);
    assign w_target     = (br_type == 2'b11) ? ((rs1data_de + imm_de) & ~XLEN'(1))
                                             : (pc_de + imm_de);

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        req_d     = req_q;
        rpc_d     = rpc_q;
        flush_d   = flush_q;
        illegal_d = 1'b0;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_cond_ok && bcnt_q != C_CNT_MAX) begin
                        bcnt_d = bcnt_q + CNT_W'(1);
                    end
                    if (br_type == 2'b01 && w_f3_illegal) begin
                        illegal_d = 1'b1;
                    end
                    if (w_take) begin
                        state_d = REDIRECT;
                        req_d   = 1'b1;
                        rpc_d   = w_target;
                        if (tcnt_q != C_CNT_MAX) begin
                            tcnt_d = tcnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ack) begin
                    req_d = 1'b0;
                    if (C_FLUSH_INIT == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        flush_d = 1'b1;
                        fcnt_d  = C_FLUSH_INIT;
                    end
                end
            end
            FLUSH: begin
                // fcnt_q holds the flush cycles still to run, including this one
                fcnt_d = fcnt_q - 4'd1;
                if (fcnt_q == 4'd1) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fcnt_q    <= 4'd0;
            req_q     <= 1'b0;
            rpc_q     <= '0;
            flush_q   <= 1'b0;
            illegal_q <= 1'b0;
            bcnt_q    <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            req_q     <= req_d;
            rpc_q     <= rpc_d;
            flush_q   <= flush_d;
            illegal_q <= illegal_d;
            bcnt_q    <= bcnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign exec_ready   = (state_q == IDLE);
    assign redirect_req = req_q;
    assign redirect_pc  = rpc_q;
    assign flush        = flush_q;
    assign illegal_br   = illegal_q;
    assign branch_cnt   = bcnt_q;
    assign taken_cnt    = tcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_ctrl
// Purpose  : Randomized self-checking bench for jump_ctrl against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jump_ctrl;

    localparam int F    = 2;
    localparam int CMAX = 65535;
    localparam int SMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        exec_valid, jsp, ack;
    logic [1:0]  br_type;
    logic [7:0]  op;
    logic [31:0] pc, imm, rs1;
    logic        exec_ready, redirect_req, flush, illegal_br;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, taken_cnt;

    logic        s_valid, s_jsp, s_ack;
    logic [1:0]  s_br_type;
    logic [7:0]  s_op;
    logic [31:0] s_pc, s_imm, s_rs1;
    logic        s_ready, s_req, s_flush, s_ill;
    logic [31:0] s_rpc;
    logic [3:0]  s_bcnt, s_tcnt;

    int checks = 0;
    int failures = 0;
    int mb = 0;
    int mt = 0;
    int s_flush_seen = 0;

    jump_ctrl #(.XLEN(32), .OPLEN(8), .FLUSH_CYCLES(F), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .exec_valid(exec_valid), .exec_ready(exec_ready),
        .br_type(br_type), .decoded_op_de(op), .jump_state_pre(jsp), .pc_de(pc),
        .imm_de(imm), .rs1data_de(rs1), .redirect_req(redirect_req),
        .redirect_pc(redirect_pc), .redirect_ack(ack), .flush(flush),
        .illegal_br(illegal_br), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    jump_ctrl #(.XLEN(32), .OPLEN(8), .FLUSH_CYCLES(0), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .exec_valid(s_valid), .exec_ready(s_ready),
        .br_type(s_br_type), .decoded_op_de(s_op), .jump_state_pre(s_jsp), .pc_de(s_pc),
        .imm_de(s_imm), .rs1data_de(s_rs1), .redirect_req(s_req),
        .redirect_pc(s_rpc), .redirect_ack(s_ack), .flush(s_flush),
        .illegal_br(s_ill), .branch_cnt(s_bcnt), .taken_cnt(s_tcnt)
    );

    always @(negedge clk) if (rst_n && s_flush) s_flush_seen <= s_flush_seen + 1;

    // One complete transaction; starts and ends on a negedge with the DUT idle.
    task automatic do_txn(input logic [1:0] bt, input logic [2:0] f3, input logic j,
                          input logic [31:0] p, input logic [31:0] im,
                          input logic [31:0] r, input int n_ack);
        logic        e_take, e_ill, e_br;
        logic [31:0] e_tgt;
        e_take = 1'b0; e_ill = 1'b0; e_br = 1'b0; e_tgt = 32'h0;
        case (bt)
            2'b01: if (f3 == 3'b010 || f3 == 3'b011) e_ill = 1'b1;
                   else begin e_br = 1'b1; e_take = (j === 1'b1); e_tgt = p + im; end
            2'b10: begin e_take = 1'b1; e_tgt = p + im; end
            2'b11: begin e_take = 1'b1; e_tgt = (r + im) & 32'hFFFF_FFFE; end
            default: ;
        endcase
        checks++;
        if (exec_ready !== 1'b1) begin
            failures++; $display("FAIL ready_before_accept actual=%b expected=1", exec_ready);
        end
        exec_valid = 1'b1; br_type = bt; op = {1'b0, f3, 4'($urandom)};
        jsp = j; pc = p; imm = im; rs1 = r; ack = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (e_br && mb < CMAX) mb++;
        if (e_take && mt < CMAX) mt++;
        @(negedge clk);
        exec_valid = 1'b0; br_type = 2'($urandom); pc = $urandom; imm = $urandom; ack = 1'b0;
        checks++;
        if ({illegal_br, redirect_req, branch_cnt, taken_cnt} !== {e_ill, e_take, 16'(mb), 16'(mt)}) begin
            failures++;
            $display("FAIL accept ill/req/bcnt/tcnt actual=%b/%b/%0d/%0d expected=%b/%b/%0d/%0d",
                     illegal_br, redirect_req, branch_cnt, taken_cnt, e_ill, e_take, mb, mt);
        end
        if (e_take) begin
            for (int i = 1; i <= n_ack; i++) begin
                if (i > 1) @(negedge clk);
                checks++;
                if ({exec_ready, redirect_req, flush, redirect_pc} !== {3'b010, e_tgt}) begin
                    failures++;
                    $display("FAIL redirect cyc%0d rdy/req/flush/pc actual=%b%b%b/%h expected=010/%h",
                             i, exec_ready, redirect_req, flush, redirect_pc, e_tgt);
                end
                ack = (i == n_ack);
            end
            for (int k = 1; k <= F; k++) begin
                @(negedge clk);
                ack = 1'($urandom_range(0, 1));
                checks++;
                if ({exec_ready, redirect_req, flush} !== 3'b001) begin
                    failures++;
                    $display("FAIL flush cyc%0d rdy/req/flush actual=%b%b%b expected=001",
                             k, exec_ready, redirect_req, flush);
                end
            end
            @(negedge clk);
            ack = 1'b0;
        end
        checks++;
        if ({exec_ready, redirect_req, flush} !== 3'b100) begin
            failures++;
            $display("FAIL idle_after rdy/req/flush actual=%b%b%b expected=100",
                     exec_ready, redirect_req, flush);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({exec_ready, redirect_req, flush, illegal_br, redirect_pc, branch_cnt, taken_cnt}
            !== {4'b1000, 32'h0, 16'h0, 16'h0}) begin
            failures++; $display("FAIL por_state actual=%b%b%b%b/%h/%0d/%0d expected=1000/0/0/0",
                exec_ready, redirect_req, flush, illegal_br, redirect_pc, branch_cnt, taken_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        exec_valid = 1'b1; br_type = 2'b10; op = 8'h0; pc = 32'h40; imm = 32'h8; ack = 1'b1;
        @(posedge clk);
        @(negedge clk); exec_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (flush !== 1'b1) begin
            failures++; $display("FAIL rst_setup_flush actual=%b expected=1", flush);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({exec_ready, redirect_req, flush, illegal_br, redirect_pc, taken_cnt}
            !== {4'b1000, 32'h0, 16'h0}) begin
            failures++; $display("FAIL async_reset actual=%b%b%b%b/%h/%0d expected=1000/0/0",
                exec_ready, redirect_req, flush, illegal_br, redirect_pc, taken_cnt);
        end
        ack = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        mb = 0; mt = 0;
        checks++;
        if ({exec_ready, redirect_req, flush, branch_cnt, taken_cnt} !== {3'b100, 16'h0, 16'h0}) begin
            failures++; $display("FAIL post_release actual=%b%b%b/%0d/%0d expected=100/0/0",
                exec_ready, redirect_req, flush, branch_cnt, taken_cnt);
        end
    endtask

    task automatic test_beq();
        do_txn(2'b01, 3'b000, 1'b1, 32'h100, 32'h20, $urandom, 3);
        checks++;
        if ({branch_cnt, taken_cnt} !== {16'd1, 16'd1}) begin
            failures++; $display("FAIL beq_counts actual=%0d/%0d expected=1/1", branch_cnt, taken_cnt);
        end
    endtask

    task automatic test_not_taken();
        for (int i = 0; i < 5; i++) do_txn(2'b01, 3'b100, 1'b0, $urandom, $urandom, $urandom, 1);
        checks++;
        if ({branch_cnt, taken_cnt} !== {16'd6, 16'd1}) begin
            failures++; $display("FAIL blt_counts actual=%0d/%0d expected=6/1", branch_cnt, taken_cnt);
        end
    endtask

    task automatic test_jumps();
        do_txn(2'b11, 3'($urandom), 1'b0, $urandom, 32'h4, 32'h0000_1003, 1);
        do_txn(2'b10, 3'($urandom), 1'b0, 32'hFFFF_FFF0, 32'h20, $urandom, 2);
        checks++;
        if (redirect_pc !== 32'h0000_0010) begin
            failures++; $display("FAIL jal_wrap actual=%h expected=00000010", redirect_pc);
        end
    endtask

    task automatic test_illegal();
        do_txn(2'b01, 3'b011, 1'bx, $urandom, $urandom, $urandom, 1);
        do_txn(2'b01, 3'b010, 1'b1, $urandom, $urandom, $urandom, 1);
        @(negedge clk);
        checks++;
        if ({illegal_br, branch_cnt} !== {1'b0, 16'(mb)}) begin
            failures++; $display("FAIL illegal_pulse_end actual=%b/%0d expected=0/%0d",
                                 illegal_br, branch_cnt, mb);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            do_txn(2'($urandom), 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(1, 4)));
        end
    endtask

    task automatic test_saturate();
        int et;
        et = 0;
        s_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_br_type = 2'b10; s_pc = $urandom; s_imm = $urandom;
            @(posedge clk);
            if (et < SMAX) et++;
            @(negedge clk);
            s_valid = 1'b0;
            checks++;
            if ({s_req, s_flush, s_ready, s_rpc, s_tcnt} !== {3'b100, s_pc + s_imm, 4'(et)}) begin
                failures++; $display("FAIL sat_jal%0d req/flush/rdy/pc/tcnt actual=%b%b%b/%h/%0d expected=100/%h/%0d",
                    i, s_req, s_flush, s_ready, s_rpc, s_tcnt, s_pc + s_imm, et);
            end
            @(negedge clk);
            checks++;
            if ({s_req, s_flush, s_ready} !== 3'b001) begin
                failures++; $display("FAIL sat_ret%0d req/flush/rdy actual=%b%b%b expected=001",
                    i, s_req, s_flush, s_ready);
            end
        end
        s_valid = 1'b1; s_br_type = 2'b01; s_op = 8'h00; s_jsp = 1'b0;
        repeat (20) @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_bcnt, s_tcnt, s_req, 4'(s_flush_seen)} !== {4'hF, 4'hF, 1'b0, 4'h0}) begin
            failures++; $display("FAIL sat_final bcnt/tcnt/req/flushes actual=%0d/%0d/%b/%0d expected=15/15/0/0",
                s_bcnt, s_tcnt, s_req, s_flush_seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        exec_valid = 1'b0; br_type = 2'b00; op = 8'h0; jsp = 1'b0;
        pc = 32'h0; imm = 32'h0; rs1 = 32'h0; ack = 1'b0;
        s_valid = 1'b0; s_br_type = 2'b00; s_op = 8'h0; s_jsp = 1'b0;
        s_pc = 32'h0; s_imm = 32'h0; s_rs1 = 32'h0; s_ack = 1'b0;
        test_reset();
        test_beq();
        test_not_taken();
        test_jumps();
        test_illegal();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
